semaphore_phase_controller: RTL and testbench

Parametrised multi-road traffic-light controller, successor to the two-road semaphore control unit. Rotates green among `ROADS` approaches with an integrated tick-based phase timer, an all-red clearance interval, latched pedestrian push-button requests that shorten the current green, and a night flashing-yellow mode. It sits between the timebase prescaler, which supplies `tick`, and the lamp driver outputs.

---
 rtl/semaphore_pkg.sv | 25 ++
 rtl/semaphore_tick_timer.sv | 51 +++++
 rtl/semaphore_phase_controller.sv | 210 +++++++++++++++++++++
 tb/tb_semaphore_phase_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaphore_pkg.sv
// -----------------------------------------------------------------------------
// semaphore_pkg
//   Shared types and lamp encodings for the multi-road phase controller.
//   - state_e      : controller phase, encoded to match the state_flag output
//   - RED/YELLOW/GREEN/DARK : per-road lamp pattern {red,yellow,green}
//   - P_RED/P_GREEN         : per-crossing pedestrian lamp pattern {red,green}
// -----------------------------------------------------------------------------
package semaphore_pkg;

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2,
        ST_FLASH   = 2'd3
    } state_e;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    localparam logic [1:0] P_RED   = 2'b10;
    localparam logic [1:0] P_GREEN = 2'b01;

endpackage : semaphore_pkg

// File: rtl/semaphore_tick_timer.sv
// -----------------------------------------------------------------------------
// semaphore_tick_timer
//   Loadable down-counter that advances only on timebase ticks.
//   Ports:
//     clock       in   rising-edge clock
//     reset       in   asynchronous active-high reset, loads RESET_VALUE
//     load        in   load load_value this cycle (wins over tick)
//     load_value  in   CNT_W value to load
//     tick        in   decrement enable
//     count       out  current counter value
//     zero        out  count == 0
// -----------------------------------------------------------------------------
module semaphore_tick_timer #(
    parameter int               CNT_W       = 8,
    parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (tick && (count_q != '0)) begin
            // Holding at zero keeps the counter sane if the owner ever
            // lets a tick pass at zero without reloading.
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VALUE;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule : semaphore_tick_timer

// File: rtl/semaphore_phase_controller.sv
// -----------------------------------------------------------------------------
// semaphore_phase_controller
//   Rotates green among ROADS approaches: GREEN -> YELLOW -> ALL_RED -> next
//   road GREEN, with pedestrian requests shortening the green and a night
//   flashing-yellow mode entered/left through ALL_RED.
//   Ports:
//     clock        in   rising-edge clock
//     reset        in   asynchronous active-high reset
//     tick         in   timebase enable; phase timers advance only on ticks
//     night_mode   in   level request for flashing mode
//     ped_request  in   ROADS push buttons, level-sampled
//     road_lights  out  3*ROADS lamps, road i at [3i+2:3i] = {red,yellow,green}
//     ped_lights   out  2*ROADS lamps, crossing i at [2i+1:2i] = {red,green}
//     active_road  out  road owning green/yellow
//     state_flag   out  present phase (state_e encoding)
//     ped_pending  out  latched, unserved pedestrian requests
// -----------------------------------------------------------------------------
module semaphore_phase_controller
    import semaphore_pkg::*;
#(
    parameter int ROADS           = 2,
    parameter int CNT_W           = 8,
    parameter int GREEN_TICKS     = 30,
    parameter int MIN_GREEN_TICKS = 8,
    parameter int YELLOW_TICKS    = 5,
    parameter int ALL_RED_TICKS   = 2,
    parameter int FLASH_TICKS     = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       night_mode,
    input  logic [ROADS-1:0]           ped_request,
    output logic [3*ROADS-1:0]         road_lights,
    output logic [2*ROADS-1:0]         ped_lights,
    output logic [$clog2(ROADS)-1:0]   active_road,
    output logic [1:0]                 state_flag,
    output logic [ROADS-1:0]           ped_pending
);

    localparam int ACT_W = $clog2(ROADS);

    // Timer load values: a phase of N ticks starts at N-1 and exits on the
    // tick that finds the counter at zero.
    localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_GREEN_LD = CNT_W'(MIN_GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD    = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALL_RED_LD   = CNT_W'(ALL_RED_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LD     = CNT_W'(FLASH_TICKS - 1);
    localparam logic [ACT_W-1:0] LAST_ROAD    = ACT_W'(ROADS - 1);

    state_e             state_q;
    state_e             state_d;
    logic [ACT_W-1:0]   active_q;
    logic [ACT_W-1:0]   active_d;
    logic [ROADS-1:0]   ped_pending_q;
    logic [ROADS-1:0]   ped_pending_d;
    logic               flash_on_q;     // 1 = yellow half of the flash period
    logic               flash_on_d;

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_value;
    logic [CNT_W-1:0]   tmr_count;
    logic               tmr_zero;
    logic               enter_green;

    semaphore_tick_timer #(
        .CNT_W       (CNT_W),
        .RESET_VALUE (GREEN_LD)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_value),
        .tick       (tick),
        .count      (tmr_count),
        .zero       (tmr_zero)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        flash_on_d = flash_on_q;
        tmr_load   = 1'b0;
        tmr_value  = '0;

        case (state_q)
            ST_GREEN: begin
                // A waiting pedestrian on the green road trims the remaining
                // green; this reload takes the place of the tick decrement.
                if (ped_pending_q[active_q] && (tmr_count > MIN_GREEN_LD)) begin
                    tmr_load  = 1'b1;
                    tmr_value = MIN_GREEN_LD;
                end else if (tick && tmr_zero) begin
                    state_d   = ST_YELLOW;
                    tmr_load  = 1'b1;
                    tmr_value = YELLOW_LD;
                end
            end

            ST_YELLOW: begin
                if (tick && tmr_zero) begin
                    state_d   = ST_ALL_RED;
                    tmr_load  = 1'b1;
                    tmr_value = ALL_RED_LD;
                end
            end

            ST_ALL_RED: begin
                if (tick && tmr_zero) begin
                    tmr_load = 1'b1;
                    if (night_mode) begin
                        state_d    = ST_FLASH;
                        flash_on_d = 1'b1;
                        tmr_value  = FLASH_LD;
                    end else begin
                        state_d   = ST_GREEN;
                        active_d  = (active_q == LAST_ROAD) ? '0 : active_q + ACT_W'(1);
                        tmr_value = GREEN_LD;
                    end
                end
            end

            ST_FLASH: begin
                if (tick && tmr_zero) begin
                    tmr_load = 1'b1;
                    if (!night_mode) begin
                        // Parking on the last road makes the ALL_RED exit
                        // wrap green back to road 0.
                        state_d   = ST_ALL_RED;
                        active_d  = LAST_ROAD;
                        tmr_value = ALL_RED_LD;
                    end else begin
                        flash_on_d = ~flash_on_q;
                        tmr_value  = FLASH_LD;
                    end
                end
            end

            default: begin
                state_d = ST_GREEN;
            end
        endcase
    end

    assign enter_green = (state_d == ST_GREEN) && (state_q != ST_GREEN);

    // -------------------------------------------------------------------------
    // Per-road request latch and lamp decode
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ROADS; gi++) begin : g_road
            logic       is_active;
            logic [2:0] road_c;
            logic [1:0] ped_c;

            assign is_active = (active_q == ACT_W'(gi));

            // Entering green serves every crossing except the one now
            // blocked by the new green road; the clear beats a new press.
            assign ped_pending_d[gi] = (enter_green && (active_d != ACT_W'(gi)))
                                     ? 1'b0
                                     : (ped_pending_q[gi] | ped_request[gi]);

            always_comb begin
                road_c = RED;
                ped_c  = P_RED;
                case (state_q)
                    ST_GREEN: begin
                        road_c = is_active ? GREEN : RED;
                        ped_c  = is_active ? P_RED : P_GREEN;
                    end
                    ST_YELLOW:  road_c = is_active ? YELLOW : RED;
                    ST_ALL_RED: road_c = RED;
                    ST_FLASH:   road_c = flash_on_q ? YELLOW : DARK;
                    default:    road_c = RED;
                endcase
            end

            assign road_lights[3*gi +: 3] = road_c;
            assign ped_lights[2*gi +: 2]  = ped_c;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_GREEN;
            active_q      <= '0;
            ped_pending_q <= '0;
            flash_on_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_q      <= active_d;
            ped_pending_q <= ped_pending_d;
            flash_on_q    <= flash_on_d;
        end
    end

    assign active_road = active_q;
    assign state_flag  = state_q;
    assign ped_pending = ped_pending_q;

endmodule : semaphore_phase_controller

// File: tb/tb_semaphore_phase_controller.sv
// -----------------------------------------------------------------------------
// tb_semaphore_phase_controller
//   Four-road controller with default timings. A phase/elapsed-tick model
//   predicts every output each cycle; directed scenarios pin the model with
//   hand-derived literals; a randomized run exercises ticks, requests, night
//   mode and asynchronous resets.
// -----------------------------------------------------------------------------
module tb_semaphore_phase_controller;

    localparam int R  = 4;
    localparam int CW = 8;
    localparam int G  = 30;
    localparam int MG = 8;
    localparam int Y  = 5;
    localparam int AR = 2;
    localparam int FL = 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic              night_mode = 1'b0;
    logic [R-1:0]      ped_request = '0;
    logic [3*R-1:0]    road_lights;
    logic [2*R-1:0]    ped_lights;
    logic [1:0]        active_road;
    logic [1:0]        state_flag;
    logic [R-1:0]      ped_pending;

    int n_checks = 0;
    int n_pass   = 0;

    semaphore_phase_controller #(
        .ROADS           (R),
        .CNT_W           (CW),
        .GREEN_TICKS     (G),
        .MIN_GREEN_TICKS (MG),
        .YELLOW_TICKS    (Y),
        .ALL_RED_TICKS   (AR),
        .FLASH_TICKS     (FL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .night_mode  (night_mode),
        .ped_request (ped_request),
        .road_lights (road_lights),
        .ped_lights  (ped_lights),
        .active_road (active_road),
        .state_flag  (state_flag),
        .ped_pending (ped_pending)
    );

    initial forever #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // Phase numbers: 0 green, 1 yellow, 2 all-red, 3 flash.
    int           m_phase   = 0;
    int           m_road    = 0;
    int           m_elapsed = 0;   // ticks spent in the current phase
    int           m_dur     = G;   // ticks the current phase lasts
    logic [R-1:0] m_pend    = '0;
    bit           m_flash_y = 1'b0;

    function automatic void model_reset();
        m_phase   = 0;
        m_road    = 0;
        m_elapsed = 0;
        m_dur     = G;
        m_pend    = '0;
        m_flash_y = 1'b0;
    endfunction

    function automatic void model_step();
        bit entered_green;
        entered_green = 1'b0;
        if (m_phase == 0 && m_pend[m_road] && (m_dur - m_elapsed) > MG) begin
            m_dur = m_elapsed + MG;
        end else if (tick) begin
            m_elapsed++;
            if (m_elapsed >= m_dur) begin
                m_elapsed = 0;
                case (m_phase)
                    0: begin m_phase = 1; m_dur = Y; end
                    1: begin m_phase = 2; m_dur = AR; end
                    2: begin
                        if (night_mode) begin
                            m_phase = 3; m_dur = FL; m_flash_y = 1'b1;
                        end else begin
                            m_road = (m_road + 1) % R;
                            m_phase = 0; m_dur = G; entered_green = 1'b1;
                        end
                    end
                    default: begin
                        if (!night_mode) begin
                            m_phase = 2; m_dur = AR; m_road = R - 1;
                        end else begin
                            m_flash_y = !m_flash_y;
                        end
                    end
                endcase
            end
        end
        m_pend = m_pend | ped_request;
        if (entered_green)
            for (int i = 0; i < R; i++)
                if (i != m_road) m_pend[i] = 1'b0;
    endfunction

    function automatic logic [3*R-1:0] exp_road();
        logic [3*R-1:0] v;
        for (int i = 0; i < R; i++) begin
            case (m_phase)
                0:       v[3*i +: 3] = (i == m_road) ? 3'b001 : 3'b100;
                1:       v[3*i +: 3] = (i == m_road) ? 3'b010 : 3'b100;
                2:       v[3*i +: 3] = 3'b100;
                default: v[3*i +: 3] = m_flash_y ? 3'b010 : 3'b000;
            endcase
        end
        return v;
    endfunction

    function automatic logic [2*R-1:0] exp_ped();
        logic [2*R-1:0] v;
        for (int i = 0; i < R; i++)
            v[2*i +: 2] = (m_phase == 0 && i != m_road) ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(posedge clock) begin
        if (reset) model_reset();
        else       model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clock) begin
        check("model road_lights", 64'(road_lights), 64'(exp_road()));
        check("model ped_lights",  64'(ped_lights),  64'(exp_ped()));
        check("model active_road", 64'(active_road), 64'(m_road));
        check("model state_flag",  64'(state_flag),  64'(m_phase));
        check("model ped_pending", 64'(ped_pending), 64'(m_pend));
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        reset       = 1'b1;
        tick        = 1'b0;
        night_mode  = 1'b0;
        ped_request = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " road_lights"}, 64'(road_lights), 64'(12'b100_100_100_001));
        check({tag, " ped_lights"},  64'(ped_lights),  64'(8'b01_01_01_10));
        check({tag, " state_flag"},  64'(state_flag),  64'd0);
        check({tag, " active_road"}, 64'(active_road), 64'd0);
        check({tag, " ped_pending"}, 64'(ped_pending), 64'd0);
    endtask

    // Reset asserted between edges must show reset outputs before the next edge.
    task automatic mid_cycle_reset(input string tag);
        #1 reset = 1'b1;
        model_reset();
        #1 check_reset_outputs(tag);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        int idx;

        // --- reset values and idle timebase ---
        do_reset();
        check_reset_outputs("reset");
        edges(100);
        check_reset_outputs("tick0 x100");
        $display("scenario: reset and 100 clocks without tick");

        // --- rotation with tick every clock ---
        do_reset();
        tick = 1'b1;
        edges(29); check("rot green end", 64'(state_flag), 64'd0);
        edges(1);  check("rot yellow start", 64'(state_flag), 64'd1);
        check("rot yellow lamps", 64'(road_lights), 64'(12'b100_100_100_010));
        edges(4);  check("rot yellow end", 64'(state_flag), 64'd1);
        edges(1);  check("rot allred start", 64'(state_flag), 64'd2);
        edges(1);  check("rot allred end", 64'(state_flag), 64'd2);
        edges(1);  check("rot road1 green", 64'(active_road), 64'd1);
        check("rot road1 state", 64'(state_flag), 64'd0);
        edges(37); check("rot road2 green", 64'(active_road), 64'd2);
        check("rot road2 ped_lights", 64'(ped_lights), 64'(8'b01_10_01_01));
        edges(37); check("rot road3 green", 64'(active_road), 64'd3);
        edges(37); check("rot wrap road0", 64'(active_road), 64'd0);
        $display("scenario: four-road rotation 0,1,2,3,0");

        // --- pedestrian shortening on road 0 ---
        do_reset();
        tick = 1'b1;
        edges(9);
        ped_request = 4'b0001;
        edges(1);
        ped_request = '0;
        check("ped latched", 64'(ped_pending), 64'd1);
        edges(8);  check("ped green last", 64'(state_flag), 64'd0);
        edges(1);  check("ped yellow early", 64'(state_flag), 64'd1);
        edges(6);  check("ped allred pending", 64'(ped_pending), 64'd1);
        check("ped allred state", 64'(state_flag), 64'd2);
        edges(1);  check("ped cleared road1", 64'(ped_pending), 64'd0);
        check("ped road1 active", 64'(active_road), 64'd1);
        $display("scenario: pedestrian request shortens green");

        // --- night mode in and out ---
        do_reset();
        tick = 1'b1;
        edges(5);
        night_mode = 1'b1;
        edges(31); check("night allred", 64'(state_flag), 64'd2);
        edges(1);  check("night flash", 64'(state_flag), 64'd3);
        check("night flash yellow", 64'(road_lights), 64'(12'b010_010_010_010));
        check("night flash peds", 64'(ped_lights), 64'(8'b10_10_10_10));
        edges(1);  check("night flash dark", 64'(road_lights), 64'd0);
        edges(1);  check("night flash yellow2", 64'(road_lights), 64'(12'b010_010_010_010));
        night_mode = 1'b0;
        edges(1);  check("day allred", 64'(state_flag), 64'd2);
        check("day parked road", 64'(active_road), 64'd3);
        edges(1);  check("day allred2", 64'(state_flag), 64'd2);
        edges(1);  check("day road0 green", 64'(state_flag), 64'd0);
        check("day road0 active", 64'(active_road), 64'd0);
        $display("scenario: night flashing entry and exit");

        // --- asynchronous reset while in yellow ---
        do_reset();
        tick = 1'b1;
        edges(32); check("pre-reset yellow", 64'(state_flag), 64'd1);
        mid_cycle_reset("async reset");
        $display("scenario: asynchronous reset during yellow");

        // --- randomized run ---
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) night_mode = ~night_mode;
            ped_request = '0;
            if ($urandom_range(0, 19) == 0) begin
                idx = int'($urandom_range(0, R - 1));
                ped_request[idx] = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0) begin
                mid_cycle_reset("random async reset");
            end else begin
                edges(1);
            end
        end
        $display("scenario: randomized run of 4000 cycles");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_semaphore_phase_controller
